aes128_stream_core: RTL and testbench

- Byte-streamed, mode-selectable AES-128 engine. Successor to the fixed-vector Tiny Tapeout AES top.
- Plaintext/ciphertext and key are shifted in over a narrow bus and held in registers.
- The existing combinational AES_Encrypt / AES_Decrypt cores run as a multicycle path. The result is captured into a register and streamed out with a valid/ready handshake.
- Sits directly under the tt_um top. ui_in, uio and uo map onto its bus ports.

---
 rtl/aes128_stream_core.sv | 263 ++++++++++++++++++++++++++
 tb/tb_aes128_stream_core.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_stream_core.sv
// Byte-streamed AES-128 engine: shift-in block/key registers, combinational encrypt/decrypt
// cores settled over a multicycle window, registered result streamed out with valid/ready.
module aes128_stream_core #(
    parameter int unsigned BUS_W       = 8,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [BUS_W-1:0] in_data,
    input  logic             in_sel,
    input  logic             start,
    input  logic             mode,
    output logic             busy,
    output logic             err,
    output logic             out_valid,
    output logic [BUS_W-1:0] out_data,
    input  logic             out_ready
);
    localparam int unsigned BEATS  = 128 / BUS_W;
    localparam int unsigned CNT_W  = $clog2(BEATS) + 1;
    localparam int unsigned WAIT_W = 8;

    typedef logic [15:0][7:0]   blk_t;    // AES state byte j sits at index 15-j
    typedef logic [10:0][127:0] rkeys_t;
    typedef enum logic [1:0] {IDLE, COMPUTE, UNLOAD} state_e;

    function automatic logic [3:0] bi(input int j);
        return 4'(15 - j);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[3'(i)]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x, input logic inv);
        logic [7:0] b;
        if (inv) begin
            b = gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
        end else begin
            b = gf_inv(x);
            b = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
        end
        return b;
    endfunction

    function automatic blk_t sub_bytes(input blk_t s, input logic inv);
        blk_t o;
        o = '0;
        for (int j = 0; j < 16; j++) o[4'(j)] = sbox(s[4'(j)], inv);
        return o;
    endfunction

    function automatic blk_t shift_rows(input blk_t s, input logic inv);
        blk_t o;
        int   src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
                o[bi(4 * c + r)] = s[bi(4 * src + r)];
            end
        end
        return o;
    endfunction

    // Circulant coefficient row: {2,3,1,1} forward, {e,b,d,9} inverse
    function automatic blk_t mix_columns(input blk_t s, input logic inv);
        blk_t            o;
        logic [3:0][7:0] cf;
        o  = '0;
        cf = inv ? {8'h09, 8'h0d, 8'h0b, 8'h0e} : {8'h01, 8'h01, 8'h03, 8'h02};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                for (int k = 0; k < 4; k++) begin
                    o[bi(4 * c + r)] = o[bi(4 * c + r)] ^ gf_mul(cf[2'(k + 4 - r)], s[bi(4 * c + k)]);
                end
            end
        end
        return o;
    endfunction

    function automatic rkeys_t expand_key(input logic [127:0] k);
        rkeys_t           rk;
        logic [43:0][31:0] w;
        logic [3:0][31:0]  kw;
        logic [31:0]       t;
        logic [7:0]        rcon;
        rk   = '0;
        w    = '0;
        kw   = k;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[6'(i)] = kw[2'(3 - i)];
        for (int i = 4; i < 44; i++) begin
            t = w[6'(i - 1)];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16], 1'b0), sbox(t[15:8], 1'b0), sbox(t[7:0], 1'b0),
                     sbox(t[31:24], 1'b0)} ^ {rcon, 24'h000000};
                rcon = xtime(rcon);
            end
            w[6'(i)] = w[6'(i - 4)] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            rk[4'(r)] = {w[6'(4 * r)], w[6'(4 * r + 1)], w[6'(4 * r + 2)], w[6'(4 * r + 3)]};
        end
        return rk;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] blk, input rkeys_t rk);
        blk_t s;
        s = blk ^ rk[0];
        for (int r = 1; r < 10; r++) begin
            s = mix_columns(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ rk[4'(r)];
        end
        return shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ rk[10];
    endfunction

    function automatic logic [127:0] aes_decrypt(input logic [127:0] blk, input rkeys_t rk);
        blk_t s;
        s = blk ^ rk[10];
        for (int r = 9; r > 0; r--) begin
            s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[4'(r)];
            s = mix_columns(s, 1'b1);
        end
        return sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[0];
    endfunction

    state_e             state;
    state_e             state_nxt;
    logic [127:0]       blk_reg;
    logic [127:0]       key_reg;
    logic [127:0]       res_reg;
    logic [CNT_W-1:0]   blk_cnt;
    logic [CNT_W-1:0]   key_cnt;
    logic [CNT_W-1:0]   out_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               mode_reg;
    logic               loaded;
    logic               accept;
    logic               last_beat;
    logic               busy_nxt;
    logic               err_nxt;
    logic               out_valid_nxt;
    rkeys_t             round_keys;
    logic [127:0]       enc_out;
    logic [127:0]       dec_out;

    // Both cores see the frozen registers; the capture waits WAIT_CYCLES for them to settle
    always_comb begin
        round_keys = expand_key(key_reg);
        enc_out    = aes_encrypt(blk_reg, round_keys);
        dec_out    = aes_decrypt(blk_reg, round_keys);
    end

    assign loaded    = (blk_cnt == CNT_W'(BEATS)) && (key_cnt == CNT_W'(BEATS));
    assign accept    = out_valid && out_ready;
    assign last_beat = (out_cnt == CNT_W'(BEATS - 1));
    assign out_data  = res_reg[127 -: BUS_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && loaded) state_nxt = COMPUTE;
            COMPUTE: if (wait_cnt == '0) state_nxt = UNLOAD;
            UNLOAD:  if (accept && last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_nxt      = (state_nxt != IDLE);
        out_valid_nxt = (state_nxt == UNLOAD);
        err_nxt       = (state == IDLE) && start && !loaded;
    end

    // Datapath: loading only in IDLE, so COMPUTE/UNLOAD see frozen operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_reg   <= '0;
            key_reg   <= '0;
            res_reg   <= '0;
            blk_cnt   <= '0;
            key_cnt   <= '0;
            out_cnt   <= '0;
            wait_cnt  <= '0;
            mode_reg  <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            busy      <= busy_nxt;
            err       <= err_nxt;
            out_valid <= out_valid_nxt;
            case (state)
                IDLE: begin
                    if (in_valid && in_sel) begin
                        key_reg <= (key_reg << BUS_W) | 128'(in_data);
                        if (key_cnt != CNT_W'(BEATS)) key_cnt <= key_cnt + CNT_W'(1);
                    end
                    if (in_valid && !in_sel) begin
                        blk_reg <= (blk_reg << BUS_W) | 128'(in_data);
                        if (blk_cnt != CNT_W'(BEATS)) blk_cnt <= blk_cnt + CNT_W'(1);
                    end
                    if (start && loaded) begin
                        mode_reg <= mode;
                        wait_cnt <= WAIT_W'(WAIT_CYCLES - 1);
                    end
                end
                COMPUTE: begin
                    if (wait_cnt == '0) begin
                        res_reg <= mode_reg ? dec_out : enc_out;
                        out_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                UNLOAD: begin
                    if (accept) begin
                        res_reg <= res_reg << BUS_W;
                        out_cnt <= out_cnt + CNT_W'(1);
                        if (last_beat) blk_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_stream_core.sv
// Directed bench for aes128_stream_core: FIPS-197 vectors in a table plus hand-written
// sequences for rejected start, backpressure, ignored inputs and reset during unload.
module tb_aes128_stream_core;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_sel;
    logic       start;
    logic       mode;
    logic       busy;
    logic       err;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    always #5 clk = ~clk;

    aes128_stream_core #(.BUS_W(8), .WAIT_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .start     (start),
        .mode      (mode),
        .busy      (busy),
        .err       (err),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    typedef struct {
        bit           load_key;
        logic [127:0] key;
        logic [127:0] blk;
        logic         mode;
        bit           rnd;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [6];
    int   checks     = 0;
    int   errors     = 0;
    int   err_pulses = 0;

    always @(negedge clk) if (err === 1'b1) err_pulses++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_beats(input logic sel, input logic [127:0] val, input int n);
        logic [127:0] v;
        v      = val;
        in_sel = sel;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = v[127:120];
            v        = v << 8;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Returns the number of edges from the start-sampling edge until out_valid is seen
    task automatic run_start(input logic m, input bit noise, output int lat);
        start = 1'b1;
        mode  = m;
        lat   = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            start    = noise;
            mode     = noise ? ~m : m;
            in_valid = noise;
            in_sel   = 1'(cyc);
            in_data  = 8'hff;
            if (out_valid === 1'b1) begin
                lat = cyc;
                break;
            end
        end
    endtask

    task automatic collect(input bit rnd, input bit noise, input int stall_idx,
                           input logic [127:0] exp, output logic [127:0] res);
        int           n;
        int           stalls;
        logic [127:0] tmp;
        n      = 0;
        stalls = 0;
        res    = '0;
        for (int cyc = 0; cyc < 400 && n < 16; cyc++) begin
            if (n == stall_idx && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            in_valid = noise && (n < 8);
            start    = noise && (n < 8);
            in_sel   = 1'(cyc);
            in_data  = 8'hff;
            mode     = 1'(cyc);
            @(negedge clk);
            if (!out_ready) begin
                tmp = exp << (8 * n);
                check("hold_while_stalled", {out_valid, out_data}, {1'b1, tmp[127:120]});
            end
            if (out_valid === 1'b1 && out_ready) begin
                res = {res[119:0], out_data};
                n++;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        start     = 1'b0;
        if (n < 16) check("unload_beats_timeout", 128'(n), 128'd16);
    endtask

    task automatic run_op(input string name, input logic m, input bit rnd, input bit noise,
                          input int stall_idx, input logic [127:0] exp);
        int           lat;
        int           pulses0;
        logic [127:0] res;
        pulses0 = err_pulses;
        run_start(m, noise, lat);
        check({name, "_latency"}, 128'(lat), 128'd5);
        collect(rnd, noise, stall_idx, exp, res);
        check({name, "_result"}, res, exp);
        check({name, "_idle_after"}, {busy, out_valid}, 2'b00);
        check({name, "_no_err"}, 128'(err_pulses), 128'(pulses0));
    endtask

    initial begin
        logic [127:0] v;
        int           lat;
        vecs[0] = '{1'b0, C1_KEY, C1_CT, 1'b1, 1'b0, C1_PT};
        vecs[1] = '{1'b1, B_KEY,  B_PT,  1'b0, 1'b1, B_CT};
        vecs[2] = '{1'b0, B_KEY,  B_CT,  1'b1, 1'b1, B_PT};
        vecs[3] = '{1'b1, '0,     '0,    1'b0, 1'b0, Z_CT};
        vecs[4] = '{1'b0, '0,     Z_CT,  1'b1, 1'b0, '0};
        vecs[5] = '{1'b1, C1_KEY, C1_PT, 1'b0, 1'b0, C1_CT};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = 1'b0;
        start = 1'b0; mode = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, 8'h00);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Short key: 15 key bytes then 16 block bytes, start must be rejected
        load_beats(1'b1, C1_KEY, 15);
        load_beats(1'b0, C1_PT, 16);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("reject_err_pulse", err, 1'b1);
        check("reject_busy", busy, 1'b0);
        @(posedge clk); #1;
        check("reject_err_one_cycle", err, 1'b0);
        check("reject_stays_idle", {busy, out_valid}, 2'b00);
        check("reject_pulse_count", 128'(err_pulses), 128'd1);
        load_beats(1'b1, {8'h0f, 120'h0}, 1);
        run_op("c1_enc", 1'b0, 1'b0, 1'b0, -1, C1_CT);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].load_key) load_beats(1'b1, vecs[i].key, 16);
            load_beats(1'b0, vecs[i].blk, 16);
            run_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].rnd, 1'b0, -1, vecs[i].exp);
        end

        load_beats(1'b0, C1_PT, 16);
        run_op("backpressure", 1'b0, 1'b1, 1'b0, 4, C1_CT);

        load_beats(1'b0, C1_PT, 16);
        run_op("ignored_inputs", 1'b0, 1'b0, 1'b1, -1, C1_CT);
        repeat (10) @(posedge clk);
        #1;
        check("no_second_op", {busy, out_valid}, 2'b00);

        // Reset in the middle of unload; key is lost so a bare start is rejected
        load_beats(1'b0, C1_PT, 16);
        run_start(1'b0, 1'b0, lat);
        check("rst_test_latency", 128'(lat), 128'd5);
        v         = C1_CT;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_test_byte%0d", i), {out_valid, out_data}, {1'b1, v[127:120]});
            v = v << 8;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_out_data", out_data, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("post_rst_err", err, 1'b1);
        check("post_rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        check("post_rst_idle", {busy, out_valid, err}, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
